// File: rtl/ma_mem_ctrl_rv32.sv
// ma_mem_ctrl_rv32: RV32I memory-access stage sequencer.
// Drives a req/gnt/rvalid data bus with byte lanes, stalls the pipeline
// until the access completes, and returns extended load data to writeback.
// Non-memory instructions pass through with one register of latency.
// Optional build macro MA_MISALIGN_TRAP_EN: misaligned H/W accesses are
// trapped via oMisalign instead of being force-aligned.
module ma_mem_ctrl_rv32 #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iMEM,
    input  logic        iRW,
    input  logic [2:0]  iFUNCT3,
    input  logic [31:0] iADDR,
    input  logic [31:0] iWDATA,
    input  logic [4:0]  iDregADDR,
    input  logic [31:0] iDregDATA,
    output logic        oStallD,
    output logic [4:0]  oDregADDR,
    output logic [31:0] oDregDATA,
    output logic        oDregWE,
    output logic        oErr,
    output logic        oBusREQ,
    output logic        oBusWE,
    output logic [31:0] oBusADDR,
    output logic [3:0]  oBusBE,
    output logic [31:0] oBusWDATA,
    input  logic        iBusGNT,
    input  logic        iBusRVALID,
    input  logic [31:0] iBusRDATA
`ifdef MA_MISALIGN_TRAP_EN
    ,
    output logic        oMisalign
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} stateT;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} sizeT;

    stateT       state;
    stateT       stateNext;

    // Request decode (combinational from the stage inputs)
    sizeT        reqSize;
    logic        reqUnsigned;
    logic [1:0]  alignOff;
    logic [3:0]  reqBe;
    logic [31:0] reqWdata;

    // Operation latched at the start of an access
    logic        isLoadQ;
    sizeT        sizeQ;
    logic        unsignedQ;
    logic [1:0]  offQ;
    logic [4:0]  rdQ;

    logic [7:0]  cnt;
    logic        cntHit;
    logic        completeNow;
    logic        loadCapture;
    logic        timeoutNow;
    logic [31:0] shifted;
    logic [31:0] loadData;

    // Decode size/sign from funct3 and compute aligned offset, lanes and store data
    always_comb begin
        reqSize     = SZ_W;
        reqUnsigned = 1'b0;
        alignOff    = 2'b00;
        reqBe       = 4'b1111;
        reqWdata    = iWDATA;
        if (iRW) begin
            case (iFUNCT3)
                3'b000:  reqSize = SZ_B;
                3'b001:  reqSize = SZ_H;
                3'b100: begin
                    reqSize     = SZ_B;
                    reqUnsigned = 1'b1;
                end
                3'b101: begin
                    reqSize     = SZ_H;
                    reqUnsigned = 1'b1;
                end
                default: reqSize = SZ_W;
            endcase
        end else begin
            case (iFUNCT3)
                3'b000:  reqSize = SZ_B;
                3'b001:  reqSize = SZ_H;
                default: reqSize = SZ_W;
            endcase
        end
        case (reqSize)
            SZ_B: begin
                alignOff = iADDR[1:0];
                reqBe    = 4'b0001 << iADDR[1:0];
                reqWdata = {4{iWDATA[7:0]}};
            end
            SZ_H: begin
                alignOff = {iADDR[1], 1'b0};
                reqBe    = 4'b0011 << {iADDR[1], 1'b0};
                reqWdata = {2{iWDATA[15:0]}};
            end
            default: begin
                alignOff = 2'b00;
                reqBe    = 4'b1111;
                reqWdata = iWDATA;
            end
        endcase
    end

`ifdef MA_MISALIGN_TRAP_EN
    logic reqMisalign;

    // Flag halfword accesses on odd bytes and word accesses off a word boundary
    always_comb begin
        reqMisalign = 1'b0;
        case (reqSize)
            SZ_H:    reqMisalign = iADDR[0];
            SZ_W:    reqMisalign = (iADDR[1:0] != 2'b00);
            default: reqMisalign = 1'b0;
        endcase
    end
`endif

    // Extract and extend the addressed field of the returned read word
    always_comb begin
        shifted  = iBusRDATA >> {offQ, 3'b000};
        loadData = shifted;
        case (sizeQ)
            SZ_B:    loadData = unsignedQ ? {24'b0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    loadData = unsignedQ ? {16'b0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: loadData = shifted;
        endcase
    end

    // Next-state, completion/timeout detection and pipeline stall
    always_comb begin
        stateNext   = state;
        oStallD     = 1'b0;
        completeNow = 1'b0;
        loadCapture = 1'b0;
        timeoutNow  = 1'b0;
        cntHit      = ((cnt + 8'd1) == TIMEOUT_CYCLES[7:0]);
        case (state)
            IDLE: begin
                if (iMEM) begin
                    oStallD = 1'b1;
`ifdef MA_MISALIGN_TRAP_EN
                    if (reqMisalign) stateNext = DONE;
                    else             stateNext = REQ;
`else
                    stateNext = REQ;
`endif
                end
            end
            REQ: begin
                oStallD     = 1'b1;
                completeNow = iBusGNT && (!isLoadQ || iBusRVALID);
                loadCapture = iBusGNT && isLoadQ && iBusRVALID;
                timeoutNow  = !completeNow && cntHit;
                if (completeNow || timeoutNow) stateNext = DONE;
                else if (iBusGNT)              stateNext = WAIT_RD;
            end
            WAIT_RD: begin
                oStallD     = 1'b1;
                completeNow = iBusRVALID;
                loadCapture = iBusRVALID;
                timeoutNow  = !completeNow && cntHit;
                if (completeNow || timeoutNow) stateNext = DONE;
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        // Reset releases the stall immediately, independent of the clock
        if (iRST) oStallD = 1'b0;
    end

    // State register
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state <= IDLE;
        else      state <= stateNext;
    end

    // Bus outputs, writeback registers, latched op and timeout counter
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oBusREQ   <= 1'b0;
            oBusWE    <= 1'b0;
            oBusADDR  <= '0;
            oBusBE    <= '0;
            oBusWDATA <= '0;
            oDregADDR <= '0;
            oDregDATA <= '0;
            oDregWE   <= 1'b0;
            oErr      <= 1'b0;
            isLoadQ   <= 1'b0;
            sizeQ     <= SZ_B;
            unsignedQ <= 1'b0;
            offQ      <= '0;
            rdQ       <= '0;
            cnt       <= '0;
`ifdef MA_MISALIGN_TRAP_EN
            oMisalign <= 1'b0;
`endif
        end else begin
            oErr <= 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
            oMisalign <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (iMEM) begin
                        isLoadQ   <= iRW;
                        sizeQ     <= reqSize;
                        unsignedQ <= reqUnsigned;
                        offQ      <= alignOff;
                        rdQ       <= iDregADDR;
                        cnt       <= '0;
                        oDregWE   <= 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
                        if (reqMisalign) begin
                            oMisalign <= 1'b1;
                        end else begin
                            oBusREQ   <= 1'b1;
                            oBusWE    <= !iRW;
                            oBusADDR  <= {iADDR[31:2], 2'b00};
                            oBusBE    <= reqBe;
                            oBusWDATA <= reqWdata;
                        end
`else
                        oBusREQ   <= 1'b1;
                        oBusWE    <= !iRW;
                        oBusADDR  <= {iADDR[31:2], 2'b00};
                        oBusBE    <= reqBe;
                        oBusWDATA <= reqWdata;
`endif
                    end else begin
                        oDregADDR <= iDregADDR;
                        oDregDATA <= iDregDATA;
                        oDregWE   <= 1'b1;
                    end
                end
                REQ, WAIT_RD: begin
                    if (state == REQ && iBusGNT) oBusREQ <= 1'b0;
                    if (completeNow) begin
                        oDregADDR <= rdQ;
                        if (loadCapture) begin
                            oDregDATA <= loadData;
                            oDregWE   <= (rdQ != 5'd0);
                        end
                    end else if (timeoutNow) begin
                        oBusREQ   <= 1'b0;
                        oDregDATA <= '0;
                        oDregWE   <= 1'b0;
                        oErr      <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    // The completed op is still on the inputs this cycle; do not pass it through
                    oDregWE <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ma_mem_ctrl_rv32.sv
// Testbench for ma_mem_ctrl_rv32: table-driven access vectors plus
// hand-written reset-state and reset-mid-access sequences.
module tb_ma_mem_ctrl_rv32;

    logic        clk = 1'b0;
    logic        iRST;
    logic        iMEM;
    logic        iRW;
    logic [2:0]  iFUNCT3;
    logic [31:0] iADDR;
    logic [31:0] iWDATA;
    logic [4:0]  iDregADDR;
    logic [31:0] iDregDATA;
    logic        oStallD;
    logic [4:0]  oDregADDR;
    logic [31:0] oDregDATA;
    logic        oDregWE;
    logic        oErr;
    logic        oBusREQ;
    logic        oBusWE;
    logic [31:0] oBusADDR;
    logic [3:0]  oBusBE;
    logic [31:0] oBusWDATA;
    logic        iBusGNT;
    logic        iBusRVALID;
    logic [31:0] iBusRDATA;
`ifdef MA_MISALIGN_TRAP_EN
    logic        oMisalign;
`endif

    int nVec = 0;
    int nErr = 0;

    ma_mem_ctrl_rv32 #(.TIMEOUT_CYCLES(4)) dut (
        .iCLK(clk), .iRST(iRST), .iMEM(iMEM), .iRW(iRW), .iFUNCT3(iFUNCT3),
        .iADDR(iADDR), .iWDATA(iWDATA), .iDregADDR(iDregADDR), .iDregDATA(iDregDATA),
        .oStallD(oStallD), .oDregADDR(oDregADDR), .oDregDATA(oDregDATA),
        .oDregWE(oDregWE), .oErr(oErr), .oBusREQ(oBusREQ), .oBusWE(oBusWE),
        .oBusADDR(oBusADDR), .oBusBE(oBusBE), .oBusWDATA(oBusWDATA),
        .iBusGNT(iBusGNT), .iBusRVALID(iBusRVALID), .iBusRDATA(iBusRDATA)
`ifdef MA_MISALIGN_TRAP_EN
        , .oMisalign(oMisalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mem;
        logic        rw;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] ddata;
        int          gntDly;
        int          rvDly;
        logic [31:0] rdata;
        logic [31:0] expBusAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expData;
        logic        chkData;
        logic        expDWe;
        logic        expErr;
        int          expStall;
    } vecT;

    vecT vecs[17];

    function automatic vecT ptV(input logic [4:0] rd, input logic [31:0] d);
        vecT v;
        v = '{default: '0};
        v.mem = 1'b0; v.rd = rd; v.ddata = d;
        v.expData = d; v.chkData = 1'b1; v.expDWe = 1'b1;
        return v;
    endfunction

    function automatic vecT ldV(input logic [2:0] f3, input logic [31:0] addr,
                                input logic [4:0] rd, input int gntDly, input int rvDly,
                                input logic [31:0] rdata, input logic [31:0] busAddr,
                                input logic [3:0] be, input logic [31:0] data,
                                input logic dwe, input int stall);
        vecT v;
        v = '{default: '0};
        v.mem = 1'b1; v.rw = 1'b1; v.f3 = f3; v.addr = addr; v.rd = rd;
        v.wdata = 32'h5A5A_5A5A; v.gntDly = gntDly; v.rvDly = rvDly; v.rdata = rdata;
        v.expBusAddr = busAddr; v.expBe = be; v.expData = data; v.chkData = 1'b1;
        v.expDWe = dwe; v.expStall = stall;
        return v;
    endfunction

    function automatic vecT stV(input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input int gntDly,
                                input logic [31:0] busAddr, input logic [3:0] be,
                                input logic [31:0] busWdata, input int stall);
        vecT v;
        v = '{default: '0};
        v.mem = 1'b1; v.rw = 1'b0; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rd = 5'd1; v.gntDly = gntDly; v.rdata = 32'hFFFF_FFFF;
        v.expBusAddr = busAddr; v.expBe = be; v.expWdata = busWdata;
        v.expDWe = 1'b0; v.expStall = stall;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Starts and ends one time unit after a rising edge
    task automatic runPass(input int idx, input vecT v);
        iMEM = 1'b0; iDregADDR = v.rd; iDregDATA = v.ddata;
        iBusGNT = 1'b0; iBusRVALID = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d stall", idx), {31'b0, oStallD}, 32'd0);
        @(posedge clk); #1;
        chk($sformatf("v%0d dregAddr", idx), {27'b0, oDregADDR}, {27'b0, v.rd});
        chk($sformatf("v%0d dregData", idx), oDregDATA, v.expData);
        chk($sformatf("v%0d dregWE", idx), {31'b0, oDregWE}, 32'd1);
    endtask

    task automatic runMem(input int idx, input vecT v);
        int  stall;
        bit  done;
        stall = 0;
        done  = 1'b0;
        iMEM = 1'b1; iRW = v.rw; iFUNCT3 = v.f3; iADDR = v.addr; iWDATA = v.wdata;
        iDregADDR = v.rd; iDregDATA = 32'h0BAD_0BAD; iBusRDATA = v.rdata;
        for (int c = 0; c < 20 && !done; c++) begin
            iBusGNT    = (c > 0) && (c == 1 + v.gntDly);
            iBusRVALID = v.rw && (c > 0) && (c == 1 + v.gntDly + v.rvDly);
            @(negedge clk);
            if (c == 1) begin
                chk($sformatf("v%0d busREQ", idx), {31'b0, oBusREQ}, 32'd1);
                chk($sformatf("v%0d busWE", idx), {31'b0, oBusWE}, {31'b0, !v.rw});
                chk($sformatf("v%0d busADDR", idx), oBusADDR, v.expBusAddr);
                chk($sformatf("v%0d busBE", idx), {28'b0, oBusBE}, {28'b0, v.expBe});
                if (!v.rw) chk($sformatf("v%0d busWDATA", idx), oBusWDATA, v.expWdata);
            end
            if (!oStallD) begin
                done = 1'b1;
            end else begin
                stall++;
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            nVec++;
            nErr++;
            $display("FAIL v%0d release: stall still high after 20 cycles, expected release", idx);
        end
        chk($sformatf("v%0d stallCycles", idx), stall, v.expStall);
        chk($sformatf("v%0d doneBusREQ", idx), {31'b0, oBusREQ}, 32'd0);
        chk($sformatf("v%0d doneErr", idx), {31'b0, oErr}, {31'b0, v.expErr});
        chk($sformatf("v%0d doneDregWE", idx), {31'b0, oDregWE}, {31'b0, v.expDWe});
        if (v.chkData) chk($sformatf("v%0d doneDregData", idx), oDregDATA, v.expData);
        if (v.expDWe)  chk($sformatf("v%0d doneDregAddr", idx), {27'b0, oDregADDR}, {27'b0, v.rd});
        @(posedge clk); #1;
        iMEM = 1'b0; iBusGNT = 1'b0; iBusRVALID = 1'b0;
        chk($sformatf("v%0d postWE", idx), {31'b0, oDregWE}, 32'd0);
        chk($sformatf("v%0d postErr", idx), {31'b0, oErr}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = ptV(5'd5, 32'h1234_5678);
        vecs[1]  = ldV(3'b000, 32'h0000_1003, 5'd7, 1, 1, 32'h80AA_BBCC, 32'h0000_1000, 4'b1000, 32'hFFFF_FF80, 1'b1, 4);
        vecs[2]  = stV(3'b001, 32'h0000_2002, 32'h0000_BEEF, 0, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 2);
        vecs[3]  = ldV(3'b101, 32'h0000_0000, 5'd3, 0, 0, 32'h0000_F00D, 32'h0000_0000, 4'b0011, 32'h0000_F00D, 1'b1, 2);
        vecs[4]  = ldV(3'b001, 32'h0000_0012, 5'd10, 0, 1, 32'h8001_0000, 32'h0000_0010, 4'b1100, 32'hFFFF_8001, 1'b1, 3);
        vecs[5]  = ldV(3'b100, 32'h0000_0021, 5'd11, 2, 0, 32'h0000_F500, 32'h0000_0020, 4'b0010, 32'h0000_00F5, 1'b1, 4);
        vecs[6]  = ldV(3'b010, 32'h0000_0033, 5'd12, 0, 2, 32'hDEAD_BEEF, 32'h0000_0030, 4'b1111, 32'hDEAD_BEEF, 1'b1, 4);
        vecs[7]  = stV(3'b000, 32'h0000_0042, 32'h1234_56A5, 1, 32'h0000_0040, 4'b0100, 32'hA5A5_A5A5, 3);
        vecs[8]  = stV(3'b010, 32'h0000_0050, 32'hCAFE_F00D, 0, 32'h0000_0050, 4'b1111, 32'hCAFE_F00D, 2);
        vecs[9]  = stV(3'b110, 32'h0000_0061, 32'h1122_3344, 0, 32'h0000_0060, 4'b1111, 32'h1122_3344, 2);
        vecs[10] = ldV(3'b000, 32'h0000_0070, 5'd0, 0, 0, 32'h0000_007F, 32'h0000_0070, 4'b0001, 32'h0000_007F, 1'b0, 2);
        vecs[11] = ldV(3'b011, 32'h0000_0080, 5'd13, 0, 0, 32'h1234_5678, 32'h0000_0080, 4'b1111, 32'h1234_5678, 1'b1, 2);
        vecs[12] = stV(3'b001, 32'h0000_2003, 32'hABCD_1234, 0, 32'h0000_2000, 4'b1100, 32'h1234_1234, 2);
        vecs[13] = ldV(3'b000, 32'h0000_0091, 5'd14, 1, 0, 32'h0000_4100, 32'h0000_0090, 4'b0010, 32'h0000_0041, 1'b1, 3);
        vecs[14] = ptV(5'd0, 32'h55AA_55AA);
        vecs[15] = ldV(3'b010, 32'h0000_0100, 5'd15, 99, 0, 32'h7777_7777, 32'h0000_0100, 4'b1111, 32'h0000_0000, 1'b0, 5);
        vecs[15].expErr = 1'b1;
        vecs[16] = ptV(5'd31, 32'hFFFF_FFFF);

        iRST = 1'b1; iMEM = 1'b0; iRW = 1'b0; iFUNCT3 = 3'b000; iADDR = '0; iWDATA = '0;
        iDregADDR = '0; iDregDATA = '0; iBusGNT = 1'b0; iBusRVALID = 1'b0; iBusRDATA = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk("rst busREQ", {31'b0, oBusREQ}, 32'd0);
        chk("rst busWE", {31'b0, oBusWE}, 32'd0);
        chk("rst busADDR", oBusADDR, 32'd0);
        chk("rst busBE", {28'b0, oBusBE}, 32'd0);
        chk("rst busWDATA", oBusWDATA, 32'd0);
        chk("rst dregAddr", {27'b0, oDregADDR}, 32'd0);
        chk("rst dregData", oDregDATA, 32'd0);
        chk("rst dregWE", {31'b0, oDregWE}, 32'd0);
        chk("rst err", {31'b0, oErr}, 32'd0);
        chk("rst stall", {31'b0, oStallD}, 32'd0);
        @(posedge clk); #1;
        iRST = 1'b0;

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].mem) runMem(i, vecs[i]);
            else             runPass(i, vecs[i]);
        end

        // Reset asserted during REQ drops the bus request without a clock edge
        iMEM = 1'b1; iRW = 1'b1; iFUNCT3 = 3'b010; iADDR = 32'h0000_0200; iDregADDR = 5'd9;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstReq busREQ before", {31'b0, oBusREQ}, 32'd1);
        #1 iRST = 1'b1;
        #1;
        chk("rstReq busREQ async", {31'b0, oBusREQ}, 32'd0);
        chk("rstReq stall async", {31'b0, oStallD}, 32'd0);
        @(posedge clk); #1;
        iRST = 1'b0;

        // Reset asserted during WAIT_RD; a late RVALID must not write back
        @(posedge clk); #1;
        iBusGNT = 1'b1;
        @(posedge clk); #1;
        iBusGNT = 1'b0;
        @(negedge clk);
        chk("rstWait stall before", {31'b0, oStallD}, 32'd1);
        chk("rstWait busREQ before", {31'b0, oBusREQ}, 32'd0);
        #1 iRST = 1'b1;
        #1;
        chk("rstWait stall async", {31'b0, oStallD}, 32'd0);
        chk("rstWait dregWE async", {31'b0, oDregWE}, 32'd0);
        iBusRVALID = 1'b1; iBusRDATA = 32'hAAAA_5555;
        @(posedge clk); #1;
        chk("rstWait lateRvalid inReset", oDregDATA, 32'd0);
        iMEM = 1'b0; iDregADDR = 5'd4; iDregDATA = 32'h0BAD_F00D;
        iRST = 1'b0;
        @(posedge clk); #1;
        chk("rstWait lateRvalid data", oDregDATA, 32'h0BAD_F00D);
        chk("rstWait lateRvalid addr", {27'b0, oDregADDR}, 32'd4);
        chk("rstWait lateRvalid we", {31'b0, oDregWE}, 32'd1);
        iBusRVALID = 1'b0;
        @(negedge clk);
        chk("rstWait idle stall", {31'b0, oStallD}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
